// File: rtl/constants.sv
// Shared constants and types for the data-memory subsystem.
package constants;

    localparam int ADDR_WIDTH   = 16;
    localparam int SIM_MEM_SIZE = 65536;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } dmem_state_t;

    typedef enum logic {
        DIR_READ,
        DIR_WRITE
    } dmem_dir_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the requester not granted last wins a tie.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and bus sequencer sharing data_memory between two requesters,
// with a registered one-cycle response path and a turnaround on bus direction change.
module dmem_arbiter
    import constants::*;
#(
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int TURNAROUND = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_we_i,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0][31:0]       req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [1:0]             rsp_err_o,
    output logic [31:0]            rsp_rdata_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic                   mem_re_o,
    output logic                   mem_we_o,
    inout  tri   [31:0]            mem_bus_io
);

    dmem_state_t state_q, state_d;
    dmem_dir_t   dir_q, dir_d;
    logic        last_q, last_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]        grant;
    logic              win_idx;
    logic              has_win;
    logic              win_misaligned;
    logic              bus_drive;
    dmem_dir_t         win_dir;
    logic [ADDR_W-1:0] win_addr;

    rr_arb2 u_rr_arb2 (
        .valid_i (req_valid_i),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign win_idx        = grant[1];
    assign has_win        = |grant;
    assign win_addr       = req_addr_i[win_idx];
    assign win_dir        = req_we_i[win_idx] ? DIR_WRITE : DIR_READ;
    assign win_misaligned = |win_addr[1:0];

    // The dead cycle is the one where the direction mismatch is seen; state TURN
    // then means "no access last cycle", so it re-arbitrates exactly like IDLE.
    always_comb begin
        state_d     = IDLE;
        dir_d       = dir_q;
        last_d      = last_q;
        rsp_valid_d = '0;
        rsp_err_d   = '0;
        rsp_rdata_d = '0;
        req_ready_o = '0;
        mem_addr_o  = '0;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        bus_drive   = 1'b0;
        if (!rst && has_win) begin
            if (state_q != ACCESS || win_dir == dir_q || TURNAROUND == 0) begin
                req_ready_o = grant;
                state_d     = ACCESS;
                last_d      = win_idx;
                rsp_valid_d = grant;
                if (win_misaligned) begin
                    rsp_err_d = grant;
                end else begin
                    dir_d      = win_dir;
                    mem_addr_o = win_addr;
                    if (win_dir == DIR_WRITE) begin
                        mem_we_o  = 1'b1;
                        bus_drive = 1'b1;
                    end else begin
                        mem_re_o    = 1'b1;
                        rsp_rdata_d = mem_bus_io;
                    end
                end
            end else begin
                state_d = TURN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_READ;
            last_q      <= 1'b1;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_bus_io  = bus_drive ? req_wdata_i[win_idx] : 'z;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
